// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF response collector:
// FSM state encoding, default parameter values and the vote-counter width helper.
package puf_pkg;

  localparam int CHAL_W_DEF     = 8;
  localparam int RESP_W_DEF     = 8;
  localparam int REPEAT_DEF     = 3;
  localparam int SETTLE_CYC_DEF = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_FIRE   = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Bits needed to count 0..rep ones during a vote.
  function automatic int vote_w(input int rep);
    return (rep < 1) ? 1 : $clog2(rep + 1);
  endfunction

endpackage

// File: rtl/puf_sync.sv
// Two-flop synchronizer bringing the asynchronous arbiter output into clk.
module puf_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Double-register the asynchronous input to resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: drives challenge and launch pulse, samples the
// synchronized arbiter output, majority-votes REPEAT evaluations per challenge and
// packs RESP_W voted bits into a word handed out over valid/ready.
// Optional macro PUF_STABILITY_EN adds unstable_mask (non-unanimous vote per bit).
module puf_response_collector
  import puf_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int RESP_W     = RESP_W_DEF,
  parameter int REPEAT     = REPEAT_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed_challenge,
  output logic              busy,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_pulse,
  input  logic              puf_response,
  output logic [RESP_W-1:0] resp_data,
  output logic              resp_valid,
  input  logic              resp_ready
`ifdef PUF_STABILITY_EN
  ,
  output logic [RESP_W-1:0] unstable_mask
`endif
);

  localparam int ONES_W = vote_w(REPEAT);
  localparam int K_W    = $clog2(RESP_W + 1);
  localparam int R_W    = $clog2(REPEAT + 1);
  localparam int C_W    = $clog2(SETTLE_CYC + 1);

  logic [2:0]        r_state;
  logic [C_W-1:0]    r_cnt;
  logic [K_W-1:0]    r_k;
  logic [R_W-1:0]    r_r;
  logic [ONES_W-1:0] r_ones;
  logic [CHAL_W-1:0] r_chal;
  logic              r_pulse;
  logic              r_busy;
  logic              r_valid;
  logic [RESP_W-1:0] r_data;

  logic              w_sync;
  logic [ONES_W-1:0] w_ones_next;
  logic              w_vote;
  logic [RESP_W-1:0] w_bitsel;
  logic              w_last_rep;
  logic              w_last_bit;
  logic              w_cnt_done;

  // The arbiter output is only ever observed through this synchronizer.
  puf_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (puf_response),
    .q   (w_sync)
  );

  assign w_ones_next = r_ones + ONES_W'(w_sync);
  assign w_vote      = (w_ones_next > ONES_W'(REPEAT / 2));
  assign w_bitsel    = RESP_W'(1) << r_k;
  assign w_last_rep  = (r_r == R_W'(REPEAT - 1));
  assign w_last_bit  = (r_k == K_W'(RESP_W - 1));
  assign w_cnt_done  = (r_cnt == C_W'(SETTLE_CYC - 1));

`ifdef PUF_STABILITY_EN
  logic [RESP_W-1:0] r_mask;
  logic              w_unstable;

  assign w_unstable = (w_ones_next != '0) && (w_ones_next != ONES_W'(REPEAT));

  // Record per-bit vote disagreement at the same moment the voted bit is stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == ST_SAMPLE && w_last_rep) begin
      r_mask <= w_unstable ? (r_mask | w_bitsel) : (r_mask & ~w_bitsel);
    end
  end

  assign unstable_mask = r_mask;
`endif

  // Evaluation sequencer: settle challenge, hold launch pulse, sample, vote, hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_r     <= '0;
      r_ones  <= '0;
      r_chal  <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !r_valid) begin
            r_chal  <= seed_challenge;
            r_k     <= '0;
            r_r     <= '0;
            r_ones  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
            r_state <= ST_FIRE;
          end else begin
            r_cnt <= r_cnt + C_W'(1);
          end
        end
        ST_FIRE: begin
          if (w_cnt_done) begin
            r_cnt   <= '0;
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt + C_W'(1);
          end
        end
        ST_SAMPLE: begin
          // Pulse falls here, so the challenge only moves while the pulse is low.
          r_pulse <= 1'b0;
          if (!w_last_rep) begin
            r_ones  <= w_ones_next;
            r_r     <= r_r + R_W'(1);
            r_state <= ST_SETUP;
          end else begin
            r_data <= w_vote ? (r_data | w_bitsel) : (r_data & ~w_bitsel);
            r_ones <= '0;
            r_r    <= '0;
            if (!w_last_bit) begin
              r_k     <= r_k + K_W'(1);
              r_chal  <= r_chal + CHAL_W'(1);
              r_state <= ST_SETUP;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else if (resp_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign puf_challenge = r_chal;
  assign puf_pulse     = r_pulse;
  assign resp_data     = r_data;
  assign resp_valid    = r_valid;

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboard bench for puf_response_collector with a behavioural PUF model.
module tb_puf_response_collector;

  localparam int CHAL_W     = 8;
  localparam int RESP_W     = 8;
  localparam int REPEAT     = 3;
  localparam int SETTLE_CYC = 4;
  localparam int LATENCY    = RESP_W * REPEAT * (2 * SETTLE_CYC + 1) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [CHAL_W-1:0] seed_challenge = '0;
  logic              busy;
  logic [CHAL_W-1:0] puf_challenge;
  logic              puf_pulse;
  logic              puf_response = 1'b0;
  logic [RESP_W-1:0] resp_data;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
`ifdef PUF_STABILITY_EN
  logic [RESP_W-1:0] unstable_mask;
`endif

  puf_response_collector #(
    .CHAL_W     (CHAL_W),
    .RESP_W     (RESP_W),
    .REPEAT     (REPEAT),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seed_challenge (seed_challenge),
    .busy           (busy),
    .puf_challenge  (puf_challenge),
    .puf_pulse      (puf_pulse),
    .puf_response   (puf_response),
    .resp_data      (resp_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready)
`ifdef PUF_STABILITY_EN
    ,
    .unstable_mask  (unstable_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [RESP_W-1:0] data_q[$];
`ifdef PUF_STABILITY_EN
  logic [RESP_W-1:0] mask_q[$];
`endif

  // PUF model and protocol watchers
  int                mode = 0;
  int                rise_cnt = 0;
  int                hcnt = 0;
  int                chal_viol = 0;
  int                width_viol = 0;
  logic              prev_pulse = 1'b0;
  logic [CHAL_W-1:0] prev_chal = '0;
  logic [CHAL_W-1:0] chal_seen[$];

  always @(negedge clk) begin
    if (rst) begin
      hcnt = 0;
    end else begin
      if (puf_pulse && !prev_pulse) begin
        rise_cnt++;
        chal_seen.push_back(puf_challenge);
      end
      if (puf_pulse && prev_pulse && (puf_challenge !== prev_chal)) chal_viol++;
      if (puf_pulse) begin
        hcnt++;
      end else if (hcnt != 0) begin
        if (hcnt != SETTLE_CYC + 1) width_viol++;
        hcnt = 0;
      end
    end
    prev_pulse = puf_pulse;
    prev_chal  = puf_challenge;
    case (mode)
      0:       puf_response = puf_challenge[0];
      1:       puf_response = puf_challenge[7];
      default: puf_response = (((rise_cnt - 1) % REPEAT) == 1) ? 1'b0 : 1'b1;
    endcase
  end

  // Monitor: compare every word the DUT hands over against the scoreboard.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (data_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        check("resp_data", 32'(resp_data), 32'(data_q.pop_front()));
`ifdef PUF_STABILITY_EN
        check("unstable_mask", 32'(unstable_mask), 32'(mask_q.pop_front()));
`endif
      end
    end
  end

  task automatic issue(input logic [CHAL_W-1:0] seed, input int m, input logic [RESP_W-1:0] exp_data);
    mode = m;
    rise_cnt = 0;
    chal_seen.delete();
    seed_challenge = seed;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    data_q.push_back(exp_data);
`ifdef PUF_STABILITY_EN
    mask_q.push_back((m == 2) ? 8'hFF : 8'h00);
`endif
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Cycles from the accepting edge until resp_valid is seen; optionally pokes start.
  task automatic wait_valid(input int poke_at, output int n);
    n = 0;
    while (!resp_valid && n < 1000) begin
      start = (n == poke_at);
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
  endtask

  int n;
  int hold_viol;
  int wait_n;
  logic [RESP_W-1:0] held;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulse", 32'(puf_pulse), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_data", 32'(resp_data), 32'd0);
    check("rst_chal", 32'(puf_challenge), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Word 1: response = challenge[0], seed 0x00 -> 0xAA; start poked while busy
    issue(8'h00, 0, 8'hAA);
    wait_valid(50, n);
    check("latency_w1", 32'(n), 32'(LATENCY));
    check("busy_at_valid_w1", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("valid_drop_w1", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Word 2: seed 0xFE, response = challenge[7] -> 0x03, consumer stalls 50 cycles
    resp_ready = 1'b0;
    issue(8'hFE, 1, 8'h03);
    wait_valid(-1, n);
    check("latency_w2", 32'(n), 32'(LATENCY));
    for (int k = 0; k < RESP_W; k++) begin
      if (chal_seen.size() > 3 * k)
        check("chal_seq", 32'(chal_seen[3 * k]), 32'((8'hFE + k) & 8'hFF));
      else
        check("chal_seq_missing", 32'(chal_seen.size()), 32'(3 * k + 1));
    end
    held = resp_data;
    hold_viol = 0;
    for (int i = 0; i < 50; i++) begin
      start = (i == 10 || i == 30);
      @(posedge clk);
      #1;
      if (resp_data !== held || !resp_valid || busy || puf_pulse) hold_viol++;
    end
    start = 1'b0;
    check("hold_stable", 32'(hold_viol), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_drop_w2", 32'(resp_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("no_new_word_busy", 32'(busy), 32'd0);

    // Word 3: middle evaluation of every bit flipped, base 1 -> 0xFF
    issue(8'h00, 2, 8'hFF);
    wait_valid(-1, n);
    check("latency_w3", 32'(n), 32'(LATENCY));
    @(posedge clk);
    #1;
    check("valid_drop_w3", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Abort during FIRE of bit 3, then restart with seed 0x11 -> 0x55
    issue(8'h10, 0, 8'hAA);
    wait_n = 0;
    while (rise_cnt < 10 && wait_n < 500) begin
      @(posedge clk);
      #1;
      wait_n++;
    end
    check("reach_fire_bit3", 32'(rise_cnt >= 10), 32'd1);
    check("pulse_before_abort", 32'(puf_pulse), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_pulse", 32'(puf_pulse), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(resp_valid), 32'd0);
    data_q.delete();
`ifdef PUF_STABILITY_EN
    mask_q.delete();
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(8'h11, 0, 8'h55);
    wait_valid(-1, n);
    check("latency_w4", 32'(n), 32'(LATENCY));
    @(posedge clk);
    #1;
    check("valid_drop_w4", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Protocol watchers and scoreboard drain
    check("chal_stable_in_pulse", 32'(chal_viol), 32'd0);
    check("pulse_high_time", 32'(width_viol), 32'd0);
    check("words_outstanding", 32'(data_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
